seven_seg_scan: RTL and testbench

- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode/cathode seven-segment digits.
- Decodes 4-bit hex nibbles (0-F) per digit and scans one digit at a time at a programmable refresh rate.
- Supports per-digit blanking, decimal points and tear-free frame-synchronous value update.
- Sits between the result registers of the sequential multiplier and the board display pins.

---
 rtl/seven_seg_pkg.sv | 29 ++
 rtl/seven_seg_hex_dec.sv | 19 +
 rtl/seven_seg_scan.sv | 134 +++++++++++++
 tb/tb_seven_seg_scan.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_pkg
//  Purpose  : Shared constants for the seven-segment scan driver: segment
//             bit positions, the all-off pattern and the hex decode table.
//  Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  // Bit positions inside a 7-bit segment vector (gfedcba ordering)
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high pattern with every segment dark
  localparam logic [6:0] SEG_ALL_OFF = 7'h00;

  // Active-high segment patterns for hex digits 0..F
  localparam logic [6:0] HEX_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage
`default_nettype wire

// File: rtl/seven_seg_hex_dec.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_hex_dec
//  Purpose  : Combinational hex nibble to active-high segment pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_hex_dec (
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);
  import seven_seg_pkg::*;

  // Table lookup; polarity is handled by the caller
  always_comb begin
    pattern = HEX_TABLE[nibble];
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan
//  Purpose  : Time-multiplexed NUM_DIGITS seven-segment driver with per-digit
//             blanking, decimal points and frame-synchronous data update.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);
  import seven_seg_pkg::*;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // XOR masks that turn active-high values into the board polarity
  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [PW-1:0]             presc;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   pend_value;
  logic [NUM_DIGITS-1:0]     pend_blank;
  logic [NUM_DIGITS-1:0]     pend_dp;
  logic                      pend_valid;
  logic [4*NUM_DIGITS-1:0]   shadow_value;
  logic [NUM_DIGITS-1:0]     shadow_blank;
  logic [NUM_DIGITS-1:0]     shadow_dp;

  logic                      digit_tick;
  logic                      wrap;
  logic [3:0]                cur_nibble;
  logic                      cur_blank;
  logic                      cur_dp;
  logic [6:0]                cur_pattern;
  logic [NUM_DIGITS-1:0]     cur_onehot;

  // Terminal-count and end-of-frame detection
  always_comb begin
    digit_tick = (presc == PRESC_LAST);
    wrap       = digit_tick && (idx == IDX_LAST);
  end

  // Select the active digit's shadow data and build its one-hot enable
  always_comb begin
    cur_nibble      = shadow_value[{idx, 2'b00} +: 4];
    cur_blank       = shadow_blank[idx];
    cur_dp          = shadow_dp[idx];
    cur_onehot      = '0;
    cur_onehot[idx] = 1'b1;
  end

  seven_seg_hex_dec u_hex_dec (
    .nibble  (cur_nibble),
    .pattern (cur_pattern)
  );

  // Prescaler and digit index; index advances on each prescaler terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (digit_tick) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Pending/shadow double buffer: shadow only changes at the frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_value   <= '0;
      pend_blank   <= '0;
      pend_dp      <= '0;
      pend_valid   <= 1'b0;
      shadow_value <= '0;
      shadow_blank <= '0;
      shadow_dp    <= '0;
    end else if (wrap) begin
      // A load coinciding with the wrap bypasses the pending stage
      pend_valid <= 1'b0;
      if (load) begin
        shadow_value <= value;
        shadow_blank <= blank;
        shadow_dp    <= dp_in;
      end else if (pend_valid) begin
        shadow_value <= pend_value;
        shadow_blank <= pend_blank;
        shadow_dp    <= pend_dp;
      end
    end else if (load) begin
      pend_value <= value;
      pend_blank <= blank;
      pend_dp    <= dp_in;
      pend_valid <= 1'b1;
    end
  end

  // Registered pin drivers with blanking and polarity applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_ALL_OFF ^ SEG_INV;
      dp         <= DP_INV;
      an         <= AN_INV;
      frame_done <= 1'b0;
    end else begin
      seg        <= (cur_blank ? SEG_ALL_OFF : cur_pattern) ^ SEG_INV;
      dp         <= (cur_dp & ~cur_blank) ^ DP_INV;
      an         <= cur_onehot ^ AN_INV;
      frame_done <= wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_seven_seg_scan
//  Purpose  : Randomised scoreboard bench for seven_seg_scan, with an
//             active-high instance and an inverted-polarity instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

  localparam int N     = 4;
  localparam int C     = 4;
  localparam int FRAME = N * C;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  dp_in = '0;
  logic        load  = 1'b0;

  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        fd;

  logic [15:0] zero_value = '0;
  logic [3:0]  zero_nib   = '0;
  logic        zero_bit   = 1'b0;
  logic [6:0]  seg_l;
  logic        dp_l;
  logic [3:0]  an_l;
  logic        fd_l;

  always #5 clk = ~clk;

  seven_seg_scan #(.NUM_DIGITS(N), .CLK_DIV(C), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .blank(blank), .dp_in(dp_in),
    .load(load), .seg(seg), .dp(dp), .an(an), .frame_done(fd)
  );

  seven_seg_scan #(.NUM_DIGITS(N), .CLK_DIV(C), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_low (
    .clk(clk), .rst_n(rst_n), .value(zero_value), .blank(zero_nib), .dp_in(zero_nib),
    .load(zero_bit), .seg(seg_l), .dp(dp_l), .an(an_l), .frame_done(fd_l)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
    logic [6:0] seg_l;
    logic       dp_l;
    logic [3:0] an_l;
    logic       fd_l;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned k        = 0;   // rising edges since reset release

  logic [6:0] hex_seg [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Reference model: frame number and digit slot come from the edge count;
  // the displayed data is whatever was latest loaded before the frame began.
  initial begin : model
    logic [15:0] shown_value, pend_value;
    logic [3:0]  shown_blank, pend_blank, shown_dp, pend_dp;
    bit          pv;
    exp_t        e;
    int          d;
    shown_value = '0; shown_blank = '0; shown_dp = '0;
    pend_value  = '0; pend_blank  = '0; pend_dp  = '0; pv = 0;
    forever begin
      @(posedge clk);
      e = '0;
      if (!rst_n) begin
        k = 0;
        shown_value = '0; shown_blank = '0; shown_dp = '0;
        pend_value  = '0; pend_blank  = '0; pend_dp  = '0; pv = 0;
        e.seg_l = 7'h7F; e.dp_l = 1'b1; e.an_l = 4'hF;
      end else begin
        k++;
        d = int'(((k - 1) / C) % N);
        e.seg   = shown_blank[d] ? 7'h00 : hex_seg[shown_value[4*d +: 4]];
        e.dp    = shown_dp[d] && !shown_blank[d];
        e.an    = '0;
        e.an[d] = 1'b1;
        e.fd    = ((k % FRAME) == 0);
        e.seg_l = ~hex_seg[0];
        e.dp_l  = 1'b1;
        e.an_l  = ~e.an;
        e.fd_l  = e.fd;
        if ((k % FRAME) == 0) begin
          if (load) begin
            shown_value = value; shown_blank = blank; shown_dp = dp_in;
          end else if (pv) begin
            shown_value = pend_value; shown_blank = pend_blank; shown_dp = pend_dp;
          end
          pv = 0;
        end else if (load) begin
          pend_value = value; pend_blank = blank; pend_dp = dp_in; pv = 1;
        end
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: outputs are sampled on the falling edge against queued expectations
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seg",          32'(seg),   32'(e.seg));
        check("dp",           32'(dp),    32'(e.dp));
        check("an",           32'(an),    32'(e.an));
        check("frame_done",   32'(fd),    32'(e.fd));
        check("seg_lowpol",   32'(seg_l), 32'(e.seg_l));
        check("dp_lowpol",    32'(dp_l),  32'(e.dp_l));
        check("an_lowpol",    32'(an_l),  32'(e.an_l));
        check("frame_lowpol", 32'(fd_l),  32'(e.fd_l));
      end
    end
  end

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] b, input logic [3:0] p);
    value = v; blank = b; dp_in = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait (on falling edges) until the next rising edge has frame offset rem
  task automatic wait_slot(input int rem);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (int'((k + 1) % FRAME) == rem) return;
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_slot timeout: slot %0d not reached", rem);
  endtask

  initial begin : stimulus
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * FRAME);

    load_once(16'h12AF, 4'b0000, 4'b0100);
    idle(2 * FRAME);

    wait_slot(5);
    load_once(16'h1111, 4'b0000, 4'b0000);
    wait_slot(12);
    load_once(16'h2222, 4'b0000, 4'b0000);
    idle(2 * FRAME);

    wait_slot(0);
    load_once(16'h3C5D, 4'b0000, 4'b1001);
    idle(2 * FRAME);

    load_once(16'h8888, 4'b1010, 4'b1111);
    idle(2 * FRAME);

    for (int i = 0; i < 300; i++) begin
      value = 16'($urandom);
      blank = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      dp_in = 4'($urandom_range(0, 15));
      load  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    load = 1'b0;
    idle(FRAME);

    // Leave a pending load, then reset while digit 2 is lit
    wait_slot(3);
    load_once(16'hFFFF, 4'b0000, 4'b1111);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (int'(((k - 1) / C) % N) == 2 && (k % FRAME) != 0) break;
      @(negedge clk);
    end
    check("digit2_before_reset", 32'(an), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("async_seg",    32'(seg),   32'h00);
    check("async_an",     32'(an),    32'h0);
    check("async_dp",     32'(dp),    32'h0);
    check("async_seg_lo", 32'(seg_l), 32'h7F);
    check("async_an_lo",  32'(an_l),  32'hF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * FRAME);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
